// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// the default handler entry address and small combinational helpers.
package irq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PEND = 3'd1,
        ST_TAKE = 3'd2,
        ST_SERV = 3'd3,
        ST_RET  = 3'd4
    } irq_state_e;

    // Handler entry address; bit 31 marks kernel space.
    localparam logic [31:0] IRQ_VECTOR_DEFAULT = 32'h8000_0004;

    // An interrupt may only be taken when neither the IF nor the ID stage
    // holds kernel code and no load-use bubble is being inserted.
    function automatic logic irq_safe(input logic pc_31,
                                      input logic pc_id_31,
                                      input logic stall_lw);
        irq_safe = ~pc_31 & ~pc_id_31 & ~stall_lw;
    endfunction

    // Both pipeline PCs outside kernel space.
    function automatic logic user_mode(input logic pc_31,
                                       input logic pc_id_31);
        user_mode = ~pc_31 & ~pc_id_31;
    endfunction

endpackage

// File: rtl/irq_ctrl.sv
// Single-level interrupt controller for the pipelined CPU. Accepts a level
// request from the timer, waits for a safe pipeline point, flushes IF/ID and
// redirects fetch to the handler for exactly one cycle, captures the return
// PC, and blocks nesting until the handler returns through the RET guard.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [31:0] VECTOR = IRQ_VECTOR_DEFAULT,
    parameter int          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq_req,
    input  logic              pc_31,
    input  logic              pc_id_31,
    input  logic              stall_lw,
    input  logic              eret,
    input  logic [31:0]       epc_in,
    output logic              irq_take,
    output logic [31:0]       irq_vector,
    output logic              irq_ack,
    output logic [31:0]       epc,
    output logic              irq_pending,
    output logic              in_service,
    output logic [CNT_W-1:0]  irq_count
);

    irq_state_e       state_q;
    irq_state_e       state_d;
    logic [31:0]      epc_q;
    logic [31:0]      epc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // State, return-address and counter registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            epc_q   <= 32'h0000_0000;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: request acceptance, safe-point wait and service tracking.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (irq_req && user_mode(pc_31, pc_id_31)) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (!irq_req) begin
                    state_d = ST_IDLE;
                end else if (irq_safe(pc_31, pc_id_31, stall_lw)) begin
                    state_d = ST_TAKE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_TAKE: begin
                state_d = ST_SERV;
            end
            ST_SERV: begin
                // Requests are ignored here: no nesting.
                if (eret) begin
                    state_d = ST_RET;
                end else begin
                    state_d = ST_SERV;
                end
            end
            ST_RET: begin
                // One refill cycle before a new request may be considered.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Return-address capture and saturating take counter, both only in TAKE.
    always_comb begin
        epc_d = epc_q;
        cnt_d = cnt_q;
        if (state_q == ST_TAKE) begin
            epc_d = epc_in;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            epc_d = epc_q;
            cnt_d = cnt_q;
        end
    end

    // Moore outputs decoded purely from the state register.
    assign irq_take    = (state_q == ST_TAKE);
    assign irq_ack     = (state_q == ST_TAKE);
    assign irq_pending = (state_q == ST_PEND);
    assign in_service  = (state_q == ST_TAKE) || (state_q == ST_SERV) ||
                         (state_q == ST_RET);
    assign irq_vector  = VECTOR;
    assign epc         = epc_q;
    assign irq_count   = cnt_q;

endmodule
